// File: rtl/game_state_ctrl.sv
// Game state controller: menu / play / pause / game-over screens, SRAM screen offset,
// restart pulse, per-player death tracking and winner detection.
// All outputs registered (one cycle after the sampled key press or death); no backpressure.
module game_state_ctrl #(
  parameter int                MAX_PLAYERS   = 2,
  parameter int                ADDR_W        = 20,
  parameter logic [ADDR_W-1:0] SCREEN_STRIDE = ADDR_W'(76800),
  parameter int                DEAD_TIMEOUT  = 150_000_000,
  parameter int                TIMER_W       = 28
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [7:0]             keycode,
  input  logic [MAX_PLAYERS-1:0] dead,
  output logic [ADDR_W-1:0]      sram_offset,
  output logic                   restart,
  output logic                   in_game,
  output logic                   paused,
  output logic                   dead_state,
  output logic [2:0]             num_players,
  output logic [MAX_PLAYERS-1:0] player_active,
  output logic                   winner_valid,
  output logic [1:0]             winner_id
);

  // HID keycodes the controller reacts to
  localparam logic [7:0]         KEY_E       = 8'd8;
  localparam logic [7:0]         KEY_P       = 8'd19;
  localparam logic [7:0]         KEY_R       = 8'd21;
  localparam logic [7:0]         KEY_ENTER   = 8'd40;
  localparam logic [7:0]         KEY_1P      = 8'd30;
  localparam logic [7:0]         KEY_LAST_NP = 8'(29 + MAX_PLAYERS);
  localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(DEAD_TIMEOUT - 1);

  // State index doubles as the screen number in SRAM
  typedef enum logic [1:0] {
    S_MENU     = 2'd0,
    S_PLAYING  = 2'd1,
    S_PAUSED   = 2'd2,
    S_GAMEOVER = 2'd3
  } state_t;

  state_t                 r_state;
  logic [7:0]             r_keycode_q;
  logic [TIMER_W-1:0]     r_timer;
  logic [ADDR_W-1:0]      r_sram_offset;
  logic                   r_restart;
  logic [2:0]             r_num_players;
  logic [MAX_PLAYERS-1:0] r_player_active;
  logic                   r_winner_valid;
  logic [1:0]             r_winner_id;

  state_t                 w_state_nxt;
  logic [TIMER_W-1:0]     w_timer_nxt;
  logic [ADDR_W-1:0]      w_offset_nxt;
  logic                   w_restart_nxt;
  logic [2:0]             w_num_players_nxt;
  logic [MAX_PLAYERS-1:0] w_active_nxt;
  logic                   w_winner_valid_nxt;
  logic [1:0]             w_winner_id_nxt;

  logic                   w_press;
  logic                   w_menu_sel;
  logic [2:0]             w_sel_players;
  logic [MAX_PLAYERS-1:0] w_menu_mask;
  logic [MAX_PLAYERS-1:0] w_full_mask;
  logic [MAX_PLAYERS-1:0] w_survivors;
  logic [2:0]             w_alive_cnt;
  logic [1:0]             w_survivor_id;
  logic                   w_game_over;

  // A press is a new nonzero keycode; held keys fire only on their first cycle
  assign w_press       = (keycode != 8'd0) && (keycode != r_keycode_q);
  assign w_menu_sel    = w_press && (keycode >= KEY_1P) && (keycode <= KEY_LAST_NP);
  assign w_sel_players = 3'(keycode - 8'd29);
  assign w_survivors   = r_player_active & ~dead;

  // Alive masks: one for a fresh game from the menu, one for a rematch with the same player count
  always_comb begin
    w_menu_mask = '0;
    w_full_mask = '0;
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      w_menu_mask[i] = (int'(w_sel_players) > i);
      w_full_mask[i] = (int'(r_num_players) > i);
    end
  end

  // Count survivors after this cycle's deaths and remember which one is left
  always_comb begin
    w_alive_cnt   = '0;
    w_survivor_id = '0;
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      if (w_survivors[i]) begin
        w_alive_cnt   = w_alive_cnt + 3'd1;
        w_survivor_id = 2'(i);
      end
    end
  end

  // Single player ends when nobody is alive; multiplayer ends at one or fewer survivors
  assign w_game_over = (r_num_players == 3'd1) ? (w_alive_cnt == 3'd0) : (w_alive_cnt <= 3'd1);

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt        = r_state;
    w_timer_nxt        = '0;
    w_restart_nxt      = 1'b0;
    w_num_players_nxt  = r_num_players;
    w_active_nxt       = r_player_active;
    w_winner_valid_nxt = r_winner_valid;
    w_winner_id_nxt    = r_winner_id;

    unique case (r_state)
      S_MENU: begin
        if (w_menu_sel) begin
          w_state_nxt        = S_PLAYING;
          w_num_players_nxt  = w_sel_players;
          w_active_nxt       = w_menu_mask;
          w_restart_nxt      = 1'b1;
          w_winner_valid_nxt = 1'b0;
          w_winner_id_nxt    = '0;
        end
      end

      S_PLAYING: begin
        // Exit beats game-over, which beats pause
        if (w_press && (keycode == KEY_E)) begin
          w_state_nxt        = S_MENU;
          w_active_nxt       = '0;
          w_winner_valid_nxt = 1'b0;
          w_winner_id_nxt    = '0;
        end else if (w_game_over) begin
          w_state_nxt        = S_GAMEOVER;
          w_active_nxt       = w_survivors;
          w_winner_valid_nxt = (r_num_players > 3'd1) && (w_alive_cnt == 3'd1);
          w_winner_id_nxt    = ((r_num_players > 3'd1) && (w_alive_cnt == 3'd1)) ? w_survivor_id : 2'd0;
        end else begin
          w_active_nxt = w_survivors;
          if (w_press && (keycode == KEY_P)) begin
            w_state_nxt = S_PAUSED;
          end
        end
      end

      S_PAUSED: begin
        // Deaths are ignored while paused; the mask stays frozen
        if (w_press && (keycode == KEY_P)) begin
          w_state_nxt = S_PLAYING;
        end else if (w_press && (keycode == KEY_E)) begin
          w_state_nxt        = S_MENU;
          w_active_nxt       = '0;
          w_winner_valid_nxt = 1'b0;
          w_winner_id_nxt    = '0;
        end
      end

      S_GAMEOVER: begin
        // A rematch press in the timeout's last cycle still wins
        if (w_press && (keycode == KEY_R)) begin
          w_state_nxt        = S_PLAYING;
          w_active_nxt       = w_full_mask;
          w_restart_nxt      = 1'b1;
          w_winner_valid_nxt = 1'b0;
          w_winner_id_nxt    = '0;
        end else if ((w_press && (keycode == KEY_ENTER)) || (r_timer == TIMER_LAST)) begin
          w_state_nxt        = S_MENU;
          w_active_nxt       = '0;
          w_winner_valid_nxt = 1'b0;
          w_winner_id_nxt    = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      default: w_state_nxt = S_MENU;
    endcase
  end

  // Screen base address for the upcoming state
  always_comb begin
    w_offset_nxt = '0;
    unique case (w_state_nxt)
      S_MENU:     w_offset_nxt = '0;
      S_PLAYING:  w_offset_nxt = SCREEN_STRIDE;
      S_PAUSED:   w_offset_nxt = SCREEN_STRIDE << 1;
      S_GAMEOVER: w_offset_nxt = SCREEN_STRIDE + (SCREEN_STRIDE << 1);
      default:    w_offset_nxt = '0;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state         <= S_MENU;
      r_keycode_q     <= '0;
      r_timer         <= '0;
      r_sram_offset   <= '0;
      r_restart       <= 1'b0;
      r_num_players   <= '0;
      r_player_active <= '0;
      r_winner_valid  <= 1'b0;
      r_winner_id     <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_keycode_q     <= keycode;
      r_timer         <= w_timer_nxt;
      r_sram_offset   <= w_offset_nxt;
      r_restart       <= w_restart_nxt;
      r_num_players   <= w_num_players_nxt;
      r_player_active <= w_active_nxt;
      r_winner_valid  <= w_winner_valid_nxt;
      r_winner_id     <= w_winner_id_nxt;
    end
  end

  assign sram_offset   = r_sram_offset;
  assign restart       = r_restart;
  assign in_game       = (r_state == S_PLAYING);
  assign paused        = (r_state == S_PAUSED);
  assign dead_state    = (r_state == S_GAMEOVER);
  assign num_players   = r_num_players;
  assign player_active = r_player_active;
  assign winner_valid  = r_winner_valid;
  assign winner_id     = r_winner_id;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: vector table, corner-case sequences, and random stimulus
// against a screen-level reference model. Two players, short game-over timeout.
module tb_game_state_ctrl;
  localparam int MAXP   = 2;
  localparam int TOUT   = 8;
  localparam int STRIDE = 76800;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [7:0]  keycode = 8'd0;
  logic [1:0]  dead = 2'd0;
  logic [19:0] sram_offset;
  logic        restart, in_game, paused, dead_state, winner_valid;
  logic [2:0]  num_players;
  logic [1:0]  player_active, winner_id;

  game_state_ctrl #(
    .MAX_PLAYERS(MAXP), .ADDR_W(20), .SCREEN_STRIDE(20'd76800),
    .DEAD_TIMEOUT(TOUT), .TIMER_W(4)
  ) dut (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .dead(dead),
    .sram_offset(sram_offset), .restart(restart), .in_game(in_game),
    .paused(paused), .dead_state(dead_state), .num_players(num_players),
    .player_active(player_active), .winner_valid(winner_valid), .winner_id(winner_id)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Screen codes: 0 menu, 1 playing, 2 paused, 3 game over
  typedef struct {
    logic       rst_n;
    logic [7:0] kc;
    logic [1:0] dd;
    int         st;
    logic       rs;
    int         np;
    logic [1:0] act;
    logic       wv;
    logic [1:0] wid;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic r, input int k, input int d, input int st,
                              input logic rs, input int np, input int act,
                              input logic wv, input int wid);
    vec_t v;
    v.rst_n = r; v.kc = 8'(k); v.dd = 2'(d); v.st = st; v.rs = rs;
    v.np = np; v.act = 2'(act); v.wv = wv; v.wid = 2'(wid);
    vecs.push_back(v);
  endfunction

  task automatic cyc(input logic r, input logic [7:0] k, input logic [1:0] d);
    Reset = r; keycode = k; dead = d;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input int st, input logic rs, input int np,
                     input logic [1:0] act, input logic wv, input logic [1:0] wid);
    logic [31:0] got, exp;
    logic [19:0] off;
    off = 20'(st * STRIDE);
    got = {sram_offset, restart, in_game, paused, dead_state, num_players,
           player_active, winner_valid, winner_id};
    exp = {off, rs, st == 1, st == 2, st == 3, 3'(np), act, wv, wid};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got off=%0d rs=%b play/pause/over=%b%b%b np=%0d act=%b wv=%b wid=%0d, expected off=%0d rs=%b screen=%0d np=%0d act=%b wv=%b wid=%0d",
               name, sram_offset, restart, in_game, paused, dead_state, num_players,
               player_active, winner_valid, winner_id, off, rs, st, np, act, wv, wid);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference model kept at the level of screens, player sets and elapsed time
  int m_mode, m_prev, m_np, m_alive, m_wv, m_wid, m_rs, m_elapsed;

  task automatic model_to_menu();
    m_mode = 0; m_alive = 0; m_wv = 0; m_wid = 0;
  endtask

  task automatic model_step(input logic r, input int k, input int d);
    bit fire;
    int surv, n;
    if (!r) begin
      m_mode = 0; m_prev = 0; m_np = 0; m_alive = 0;
      m_wv = 0; m_wid = 0; m_rs = 0; m_elapsed = 0;
      return;
    end
    fire = (k != 0) && (k != m_prev);
    m_rs = 0;
    case (m_mode)
      0: if (fire && k >= 30 && k < 30 + MAXP) begin
           m_mode = 1; m_np = k - 29; m_alive = (1 << m_np) - 1;
           m_rs = 1; m_wv = 0; m_wid = 0;
         end
      1: begin
        surv = m_alive & ~d & ((1 << MAXP) - 1);
        n = $countones(surv);
        if (fire && k == 8) model_to_menu();
        else if ((m_np == 1 && n == 0) || (m_np > 1 && n <= 1)) begin
          m_mode = 3; m_alive = surv; m_elapsed = 0;
          m_wv = (m_np > 1 && n == 1) ? 1 : 0;
          m_wid = 0;
          if (m_wv == 1) for (int i = 0; i < MAXP; i++) if ((surv >> i) & 1) m_wid = i;
        end else begin
          m_alive = surv;
          if (fire && k == 19) m_mode = 2;
        end
      end
      2: begin
        if (fire && k == 19) m_mode = 1;
        else if (fire && k == 8) model_to_menu();
      end
      default: begin
        if (fire && k == 21) begin
          m_mode = 1; m_alive = (1 << m_np) - 1; m_rs = 1; m_wv = 0; m_wid = 0;
        end else if ((fire && k == 40) || m_elapsed == TOUT - 1) model_to_menu();
        else m_elapsed++;
      end
    endcase
    m_prev = k;
  endtask

  initial begin
    int n, rcnt;
    int keys[8];
    logic r;
    logic [7:0] k;
    logic [1:0] d;

    // rst, key, dead -> screen, restart, np, active, wv, wid
    add(0,  0, 0, 0, 0, 0, 0, 0, 0);  // reset state
    add(1, 30, 0, 1, 1, 1, 1, 0, 0);  // 1P start
    add(1, 30, 0, 1, 0, 1, 1, 0, 0);  // held key: no second restart
    add(1, 30, 0, 1, 0, 1, 1, 0, 0);
    add(1,  0, 1, 3, 0, 1, 0, 0, 0);  // sole player dies
    add(1, 40, 0, 0, 0, 1, 0, 0, 0);  // Enter back to menu, np kept
    add(1, 40, 0, 0, 0, 1, 0, 0, 0);
    add(1,  0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 31, 0, 1, 1, 2, 3, 0, 0);  // 2P start
    add(1,  0, 1, 3, 0, 2, 2, 1, 1);  // player 0 dies, player 1 wins
    add(1, 21, 0, 1, 1, 2, 3, 0, 0);  // rematch
    add(1,  0, 3, 3, 0, 2, 0, 0, 0);  // both die: no winner
    add(1, 21, 0, 1, 1, 2, 3, 0, 0);
    add(1, 19, 0, 2, 0, 2, 3, 0, 0);  // pause
    add(1,  0, 3, 2, 0, 2, 3, 0, 0);  // deaths ignored while paused
    add(1, 19, 3, 1, 0, 2, 3, 0, 0);  // resume without restart
    add(1,  0, 0, 1, 0, 2, 3, 0, 0);
    add(1,  8, 3, 0, 0, 2, 0, 0, 0);  // exit beats game over
    add(1,  0, 0, 0, 0, 2, 0, 0, 0);
    add(1, 40, 0, 0, 0, 2, 0, 0, 0);  // Enter ignored in menu
    add(1, 32, 0, 0, 0, 2, 0, 0, 0);  // 3P not supported
    add(1, 29, 0, 0, 0, 2, 0, 0, 0);
    add(1, 31, 0, 1, 1, 2, 3, 0, 0);
    add(1, 19, 2, 3, 0, 2, 1, 1, 0);  // game over beats pause
    add(1, 21, 0, 1, 1, 2, 3, 0, 0);
    add(1, 30, 0, 1, 0, 2, 3, 0, 0);  // key change fires, but 30 means nothing here
    add(1, 19, 0, 2, 0, 2, 3, 0, 0);
    add(0, 19, 0, 0, 0, 0, 0, 0, 0);  // reset mid-pause
    add(1, 19, 0, 0, 0, 0, 0, 0, 0);
    add(1, 31, 0, 1, 1, 2, 3, 0, 0);
    add(1,  0, 1, 3, 0, 2, 2, 1, 1);
    add(1,  0, 0, 3, 0, 2, 2, 1, 1);
    add(0, 31, 0, 0, 0, 0, 0, 0, 0);  // reset mid-game-over with key held
    add(1, 31, 0, 1, 1, 2, 3, 0, 0);  // held key fires once after reset
    add(1, 31, 0, 1, 0, 2, 3, 0, 0);
    add(0,  0, 0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst_n, vecs[i].kc, vecs[i].dd);
      chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].rs, vecs[i].np,
          vecs[i].act, vecs[i].wv, vecs[i].wid);
    end

    // Holding the start key for 10 cycles yields exactly one restart
    rcnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 30, 0);
      if (restart) rcnt++;
    end
    chk_int("held_start_restarts", rcnt, 1);

    // Auto-return: menu exactly TOUT cycles after game-over entry
    cyc(1, 0, 1);
    chk("timeout_entry", 3, 0, 1, 0, 0, 0);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1, 0, 0);
      if (!dead_state) begin n = i; break; end
    end
    chk_int("timeout_cycles", n, TOUT);
    chk("timeout_menu", 0, 0, 1, 0, 0, 0);

    // Rematch pressed during cycle 3 of game over
    cyc(1, 31, 0);
    cyc(1, 0, 3);
    chk("rematch_entry", 3, 0, 2, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    cyc(1, 21, 0);
    chk("rematch_c3", 1, 1, 2, 3, 0, 0);

    // Rematch in the timeout's last cycle beats the timeout
    cyc(1, 0, 3);
    for (int i = 0; i < TOUT - 1; i++) cyc(1, 0, 0);
    chk("last_cycle_still_over", 3, 0, 2, 0, 0, 0);
    cyc(1, 21, 0);
    chk("rematch_last_cycle", 1, 1, 2, 3, 0, 0);

    // Randomised run against the reference model
    keys = '{0, 8, 19, 21, 30, 31, 32, 40};
    cyc(0, 0, 0);
    model_step(0, 0, 0);
    k = 8'd0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 9) >= 4) k = 8'(keys[$urandom_range(0, 7)]);
      d = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      cyc(r, k, d);
      model_step(r, int'(k), int'(d));
      chk("random", m_mode, m_rs[0], m_np, 2'(m_alive), m_wv[0], 2'(m_wid));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
